// File: rtl/blur_pkg.sv
// -----------------------------------------------------------------------------
// blur_pkg
// Definitions shared by the Gaussian blur accelerator and its testbenches:
// writer state encoding, the 32-bit result word type, the default frame
// geometry, and a width helper for sizing counters.
// -----------------------------------------------------------------------------
package blur_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } blur_state_e;

  typedef logic [31:0] blur_word_t;

  localparam int unsigned BLUR_IMG_W = 256;
  localparam int unsigned BLUR_IMG_H = 256;

  // Bits needed to index n distinct values; never less than one bit.
  function automatic int unsigned blur_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blur_result_fifo.sv
// -----------------------------------------------------------------------------
// blur_result_fifo
// Small synchronous FIFO with a registered head word: head_o always holds
// the oldest stored entry, so the consumer sees the data from a flop and
// not from a read mux.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (empties the FIFO, head = 0)
//   push_i   write data_i (ignored while full)
//   data_i   word to write
//   pop_i    drop the head entry (ignored while empty)
//   head_o   oldest entry (registered)
//   full_o   DEPTH entries stored
//   empty_o  no entries stored
// -----------------------------------------------------------------------------
module blur_result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // The next head is the slot rd_ptr_d points at; if that slot is being
  // written this same cycle (FIFO empty, or draining its last entry) the
  // incoming word bypasses the array.
  always_comb begin
    head_d = mem_q[rd_ptr_d];
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/blur_result_writer.sv
// -----------------------------------------------------------------------------
// blur_result_writer
// Takes the blur core's result stream, buffers it in a small FIFO and writes
// each word to a frame buffer in raster order starting at BASE_ADDR. A
// one-cycle o_done pulse follows the last accepted write of the frame.
//
// Optional feature (compile-time macro BLUR_WRITER_CHECKSUM_EN): adds
// o_checksum, the modulo-2^32 sum of all words written in the frame.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_start          arm one frame (only acted on in IDLE)
//   o_idle, o_done   idle status; end-of-frame pulse
//   i_result_vld / o_result_busy / i_result_data   result input handshake
//   o_mem_vld / i_mem_busy / o_mem_addr / o_mem_wdata  memory write port
//   o_checksum       frame checksum (macro only)
// All outputs come from registers or decode of registered state.
// -----------------------------------------------------------------------------
module blur_result_writer
  import blur_pkg::*;
#(
  parameter int unsigned IMG_W      = BLUR_IMG_W,
  parameter int unsigned IMG_H      = BLUR_IMG_H,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_idle,
  output logic              o_done,
  input  logic              i_result_vld,
  output logic              o_result_busy,
  input  logic [31:0]       i_result_data,
  output logic              o_mem_vld,
  input  logic              i_mem_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata
`ifdef BLUR_WRITER_CHECKSUM_EN
  ,
  output logic [31:0]       o_checksum
`endif
);

  localparam int unsigned FRAME = IMG_W * IMG_H;
  localparam int unsigned CNT_W = blur_width(FRAME + 1);
  localparam int unsigned COL_W = blur_width(IMG_W);
  localparam int unsigned ROW_W = blur_width(IMG_H);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  blur_state_e       state_q;
  logic [CNT_W-1:0]  in_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  blur_word_t        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign o_result_busy = (state_q != ST_RUN) | fifo_full | (in_cnt_q == FRAME_CNT);
  assign push          = i_result_vld & ~o_result_busy;
  assign pop           = ~fifo_empty & ~i_mem_busy;

  assign o_idle      = (state_q == ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_mem_vld   = ~fifo_empty;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = fifo_head;

  blur_result_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (push),
    .data_i  (i_result_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef BLUR_WRITER_CHECKSUM_EN
  logic [31:0] cksum_q;
  assign o_checksum = cksum_q;
`endif

  // Push/pop only happen in RUN/FLUSH (busy is high and the FIFO is empty
  // elsewhere), so the IDLE start branch never competes with them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      in_cnt_q <= '0;
      wr_cnt_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= BASE;
`ifdef BLUR_WRITER_CHECKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      if (push) begin
        in_cnt_q <= in_cnt_q + 1'b1;
      end
      if (pop) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        addr_q   <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
`ifdef BLUR_WRITER_CHECKSUM_EN
        cksum_q <= cksum_q + fifo_head;
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q  <= ST_RUN;
            in_cnt_q <= '0;
            wr_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= BASE;
`ifdef BLUR_WRITER_CHECKSUM_EN
            cksum_q  <= '0;
`endif
          end
        end
        ST_RUN: begin
          // Leave on the accept of the final pixel; the FIFO drains in FLUSH.
          if (push && (in_cnt_q == FRAME_CNT - 1'b1)) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (pop && (wr_cnt_q == FRAME_CNT - 1'b1)) begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blur_result_writer.sv
// -----------------------------------------------------------------------------
// tb_blur_result_writer
// Main instance: 4x2 frame at 0x100, 16-bit addresses, 4-deep FIFO.
// Second instance: 2x2 frame at 14 with 4-bit addresses (address wrap).
// Driver pushes the expected {address, data} of each accepted result into a
// scoreboard queue; a negedge monitor pops and compares on every write.
// -----------------------------------------------------------------------------
module tb_blur_result_writer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int FRAME = IMG_W * IMG_H;
  localparam int BASE  = 32'h100;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        idle, done;
  logic        r_vld = 1'b0;
  logic        r_busy;
  logic [31:0] r_data = '0;
  logic        m_vld;
  logic        m_busy;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;

  logic        w_start = 1'b0;
  logic        w_idle, w_done;
  logic        w_vld = 1'b0;
  logic        w_busy;
  logic [31:0] w_data = '0;
  logic        w_mvld;
  logic        w_mem_busy = 1'b0;
  logic [3:0]  w_maddr;
  logic [31:0] w_mwdata;

`ifdef BLUR_WRITER_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] w_checksum;
`endif

  blur_result_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(16), .BASE_ADDR(BASE), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_idle(idle), .o_done(done),
    .i_result_vld(r_vld), .o_result_busy(r_busy), .i_result_data(r_data),
    .o_mem_vld(m_vld), .i_mem_busy(m_busy), .o_mem_addr(m_addr), .o_mem_wdata(m_wdata)
`ifdef BLUR_WRITER_CHECKSUM_EN
    , .o_checksum(checksum)
`endif
  );

  blur_result_writer #(
    .IMG_W(2), .IMG_H(2), .ADDR_W(4), .BASE_ADDR(14), .FIFO_DEPTH(4)
  ) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_start(w_start), .o_idle(w_idle), .o_done(w_done),
    .i_result_vld(w_vld), .o_result_busy(w_busy), .i_result_data(w_data),
    .o_mem_vld(w_mvld), .i_mem_busy(w_mem_busy), .o_mem_addr(w_maddr), .o_mem_wdata(w_mwdata)
`ifdef BLUR_WRITER_CHECKSUM_EN
    , .o_checksum(w_checksum)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Memory stall: either random or forced by the directed tests.
  logic rand_busy  = 1'b0;
  logic force_busy = 1'b0;
  logic rnd_bit    = 1'b0;
  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 2) == 0);
  end
  assign m_busy = rand_busy ? rnd_bit : force_busy;

  // Reference model state
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  int          acc_idx   = 0;
  logic [31:0] sum_model = '0;
  logic        gap_en    = 1'b0;

  int wr_idx   = 0;
  bit exp_done = 1'b0;
  int done_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_idx   = 0;
    sum_model = '0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    r_vld  = 1'b1;
    r_data = d;
    forever begin
      @(negedge clk);
      if (!r_busy) begin
        sb.push_back('{addr: 16'(BASE + acc_idx), data: d});
        acc_idx++;
        sum_model += d;
        break;
      end
      n++;
      if (n > 300) begin
        fail_now("accept_timeout");
        break;
      end
      tick();
    end
    tick();
    r_vld = 1'b0;
    if (gap_en) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      tick();
      n++;
    end
    if (done_cnt < target) fail_now("done_timeout");
  endtask

  // Monitor for the main instance
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      wr_idx   = 0;
      exp_done = 1'b0;
    end else begin
      if (done || exp_done) chk("done_pulse", 32'(done), 32'(exp_done));
`ifdef BLUR_WRITER_CHECKSUM_EN
      if (done) chk("checksum", checksum, sum_model);
`endif
      if (done) done_cnt++;
      exp_done = 1'b0;
      if (m_vld && !m_busy) begin
        if (sb.size() == 0) begin
          fail_now($sformatf("spurious_write addr=0x%0h data=0x%0h", m_addr, m_wdata));
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", 32'(m_addr), 32'(mon_e.addr));
          chk("wr_data", m_wdata, mon_e.data);
          wr_idx++;
          if (wr_idx == FRAME) begin
            exp_done = 1'b1;
            wr_idx   = 0;
          end
        end
      end
    end
  end

  // Monitor for the wrap instance (never stalled, so every vld is a write)
  int w_idx = 0;
  int w_done_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (w_done) w_done_cnt++;
      if (w_mvld) begin
        chk("wrap_addr", 32'(w_maddr), 32'((14 + w_idx) % 16));
        chk("wrap_data", w_mwdata, 32'(32'hA0 + w_idx));
        w_idx++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    // Reset values
    chk("rst_idle",   32'(idle),   32'd1);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_busy",   32'(r_busy), 32'd1);
    chk("rst_memvld", 32'(m_vld),  32'd0);
    chk("rst_addr",   32'(m_addr), 32'h100);
    chk("rst_wdata",  m_wdata,     32'd0);
`ifdef BLUR_WRITER_CHECKSUM_EN
    chk("rst_cksum",  checksum,    32'd0);
`endif
    rst = 1'b0;
    tick();

    // Address wrap: 2x2 frame at 14 in a 4-bit space -> 14, 15, 0, 1
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      w_vld  = 1'b1;
      w_data = 32'(32'hA0 + k);
      @(negedge clk);
      while (w_busy && n < 50) begin
        tick();
        @(negedge clk);
        n++;
      end
      tick();
    end
    w_vld = 1'b0;
    repeat (10) tick();
    chk("wrap_count", 32'(w_idx), 32'd4);
    chk("wrap_done_cnt", 32'(w_done_cnt), 32'd1);

    // Basic frame: data 1..8, no stalls
    start_frame();
    for (int k = 1; k <= FRAME; k++) send_word(32'(k));
    wait_done(1);
`ifdef BLUR_WRITER_CHECKSUM_EN
    chk("basic_cksum", checksum, 32'd36);
`endif

    // Back-pressure: memory stalled for 10 cycles from frame start
    force_busy = 1'b1;
    start_frame();
    fork
      begin
        for (int k = 0; k < FRAME; k++) send_word($urandom);
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepts", 32'(acc_idx), 32'd4);
        chk("bp_busy", 32'(r_busy), 32'd1);
        tick();
        force_busy = 1'b0;
      end
    join
    wait_done(2);

    // i_start pulsed during RUN and during FLUSH
    gap_en    = 1'b1;
    rand_busy = 1'b1;
    start_frame();
    for (int k = 0; k < FRAME; k++) begin
      if (k == FRAME - 1) begin
        rand_busy  = 1'b0;
        force_busy = 1'b1;   // keep the last word queued so we sit in FLUSH
      end
      start = (k == 3);
      send_word($urandom);
      start = 1'b0;
    end
    chk("flush_not_idle", 32'(idle), 32'd0);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    force_busy = 1'b0;
    wait_done(3);
    repeat (10) tick();
    chk("one_done_per_frame", 32'(done_cnt), 32'd3);
    chk("idle_after_frame", 32'(idle), 32'd1);

    // Reset after 3 of 8 results, then a complete frame
    gap_en    = 1'b0;
    rand_busy = 1'b1;
    start_frame();
    for (int k = 0; k < 3; k++) send_word($urandom);
    rst = 1'b1;
    tick();
    chk("midrst_idle",   32'(idle),   32'd1);
    chk("midrst_memvld", 32'(m_vld),  32'd0);
    chk("midrst_addr",   32'(m_addr), 32'h100);
    chk("midrst_done",   32'(done),   32'd0);
    rst = 1'b0;
    tick();
    start_frame();
    for (int k = 0; k < FRAME; k++) send_word($urandom);
    wait_done(4);

    // Random frames with gaps and random stalls
    gap_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      for (int k = 0; k < FRAME; k++) send_word($urandom);
      wait_done(5 + f);
    end

    // Idle blocking: valid held in IDLE must not be accepted
    rand_busy  = 1'b0;
    force_busy = 1'b0;
    repeat (3) tick();
    r_vld  = 1'b1;
    r_data = $urandom;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("idle_block_busy", 32'(r_busy), 32'd1);
    end
    chk("idle_block_memvld", 32'(m_vld), 32'd0);
    r_vld = 1'b0;
    repeat (3) tick();
    chk("final_done_cnt", 32'(done_cnt), 32'd6);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blur_result_writer.md
# blur_result_writer

Downstream stage of the Gaussian blur accelerator. It consumes the 32-bit `o_result` stream that the blur core produces over the busy/valid handshake and buffers it in a small FIFO. It writes each result word to a frame buffer at a raster-order address, then raises a one-cycle completion pulse once a full IMG_W×IMG_H frame has been committed to memory.

## Interface
- IMG_W, 256, pixels per row (≥1)
- IMG_H, 256, rows per frame (≥1)
- ADDR_W, 16, memory word-address width
- BASE_ADDR, 0, word address of pixel (0,0)
- FIFO_DEPTH, 4, result buffer entries (power of two, ≥2)

- i_clk  in  1  single clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  arm one frame; honoured only in IDLE
- o_idle  out  1  high in IDLE
- o_done  out  1  one-cycle pulse when the frame is fully written
- i_result_vld  in  1  blur core result valid
- o_result_busy  out  1  back-pressure to blur core
- i_result_data  in  32  blur result word
- o_mem_vld  out  1  write request
- i_mem_busy  in  1  memory stall
- o_mem_addr  out  ADDR_W  write word address
- o_mem_wdata  out  32  write data
- o_checksum  out  32  frame checksum (only with BLUR_WRITER_CHECKSUM_EN)

## Operation
- Handshake, both sides: a transfer occurs in a cycle where vld=1 and busy=0. Data must stay stable while vld=1 and busy=1.
- States:
  - IDLE: accept nothing. i_start → RUN, clears in_cnt, wr_cnt and the row/column counters, and sets the address to BASE_ADDR.
  - RUN: accept results until in_cnt = IMG_W*IMG_H, then go to FLUSH.
  - FLUSH: drain the FIFO. When the final write is accepted (wr_cnt reaches IMG_W*IMG_H), go to DONE.
  - DONE: o_done=1 for exactly one cycle, then go to IDLE.
- o_result_busy = (state≠RUN) | fifo_full | (in_cnt = IMG_W*IMG_H).
- Memory side is driven from the FIFO head: o_mem_vld = !fifo_empty, o_mem_wdata = head. Pop on o_mem_vld & !i_mem_busy.
- Address is generated at pop time. A column counter (0..IMG_W-1) and a row counter are held, and the address register adds 1 per accepted write. Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Simultaneous push and pop when the FIFO is full is impossible, because busy already blocks the push. A push and pop in the same cycle at any other level leaves the count unchanged.
- i_start is ignored outside IDLE. An i_start in the same cycle as the DONE→IDLE transition is also ignored.
- Reset mid-frame: all state is cleared next cycle, FIFO contents are discarded, no o_done is issued, and in-flight memory writes are abandoned.

## Timing
- Reset values: o_idle=1, o_done=0, o_result_busy=1, o_mem_vld=0, o_mem_addr=BASE_ADDR, o_mem_wdata=0, o_checksum=0.
- i_start at cycle t: o_result_busy can drop at t+1.
- Result accepted at cycle t: o_mem_vld=1 at t+1 at the earliest (registered FIFO).
- With i_mem_busy=0, sustained throughput is 1 word/cycle.
- o_done fires exactly one cycle after the last memory write is accepted.
- All outputs are registered or decoded from registered state only. There is no combinational path from i_result_vld or i_mem_busy to any output.

## Configuration
- BLUR_WRITER_CHECKSUM_EN defined:
  - o_checksum exists.
  - It is the modulo-2^32 sum of every word written to memory, cleared on an accepted i_start.
  - It holds its value from DONE until the next start.
- Not defined: the port and the accumulator are absent; everything else is identical.

## Structure
- Shared package `blur_pkg`: state enum (IDLE, RUN, FLUSH, DONE), 32-bit result word typedef, and frame-size constants reused by the blur core testbench.
- One sub-module, `blur_result_fifo`: synchronous FIFO with parameters WIDTH and DEPTH, push/pop, full/empty, and a registered head.

## Test plan
- Basic frame: IMG_W=4, IMG_H=2, BASE_ADDR=0x100, i_mem_busy=0, data 1..8.
  - Required: writes to 0x100..0x107 with data 1..8.
  - o_done one cycle after the 8th write; o_checksum=36.
- Back-pressure: hold i_mem_busy=1 for 10 cycles mid-frame.
  - o_result_busy asserts after FIFO_DEPTH accepts.
  - No data is lost or duplicated; addresses stay contiguous.
- Start outside IDLE: pulse i_start during RUN and during FLUSH.
  - No counter reset; exactly one o_done per frame.
- Reset mid-frame: assert i_rst after 3 of 8 results.
  - Next cycle: o_idle=1, o_mem_vld=0, o_mem_addr=BASE_ADDR, no o_done.
  - A new frame then completes normally.
- Address wrap: ADDR_W=4, BASE_ADDR=14, 4 pixels.
  - Required addresses 14, 15, 0, 1.
- Idle blocking: i_result_vld=1 held in IDLE.
  - o_result_busy stays 1 and no writes are issued.
